// File: rtl/nibble_port_pkg.sv
// Shared encodings for the nibble output-port responder.
package nibble_port_pkg;

  typedef enum logic {
    EXP_HI = 1'b0,
    EXP_LO = 1'b1
  } pair_state_t;

  localparam int STAT_ERR   = 3;
  localparam int STAT_FULL  = 2;
  localparam int STAT_PEND  = 1;
  localparam int STAT_EMPTY = 0;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/nibble_port_rx_fifo.sv
// Synchronous byte FIFO. Pop gates push so a full FIFO still accepts when draining.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads 8'h00 while empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/nibble_port_rx.sv
// Pairs core output-port nibbles into bytes, buffers them, and reports status
// back to the core's pushbutton input.
module nibble_port_rx
  import nibble_port_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       out_load,
  input  logic [3:0] out_data,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  input  logic       clr_err,
  output logic [3:0] status
);

  localparam int         CW  = $clog2(DEPTH) + 1;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  pair_state_t   state;
  pair_state_t   state_nxt;
  logic [3:0]    hi_nib;
  logic [7:0]    timer;
  logic          err;
  logic          push;
  logic          pop;
  logic          timeout;
  logic          overflow;
  logic          pending;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EXP_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EXP_HI:  if (out_load) state_nxt = EXP_LO;
      EXP_LO:  if (out_load || timeout) state_nxt = EXP_HI;
      default: state_nxt = EXP_HI;
    endcase
  end

  // A load on the timeout cycle takes priority, so timeout requires !out_load.
  always_comb begin
    push    = 1'b0;
    timeout = 1'b0;
    pending = 1'b0;
    if (state == EXP_LO) begin
      pending = 1'b1;
      push    = out_load;
      timeout = !out_load && (timer == TMO);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_nib <= '0;
      timer  <= '0;
    end else if (state == EXP_HI && out_load) begin
      hi_nib <= out_data;
      timer  <= '0;
    end else if (state == EXP_LO && !out_load) begin
      timer  <= timer + 8'd1;
    end
  end

  assign pop      = m_valid && m_ready;
  assign overflow = push && (fifo_count == CW'(DEPTH)) && !pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (overflow || timeout) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({hi_nib, out_data}),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;

  always_comb begin
    status             = '0;
    status[STAT_ERR]   = err;
    status[STAT_FULL]  = fifo_full;
    status[STAT_PEND]  = pending;
    status[STAT_EMPTY] = fifo_empty;
  end

endmodule

// File: tb/tb_nibble_port_rx.sv
// Scoreboard bench for nibble_port_rx with DEPTH=4, TIMEOUT=3.
module tb_nibble_port_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       out_load;
  logic [3:0] out_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       clr_err;
  logic [3:0] status;

  logic [7:0] q[$];
  int         errors = 0;
  int         checks = 0;

  nibble_port_rx #(.DEPTH(4), .TIMEOUT(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .out_load (out_load),
    .out_data (out_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .clr_err  (clr_err),
    .status   (status)
  );

  always #5 clock = ~clock;

  task automatic send_pair(input logic [3:0] hi, input logic [3:0] lo);
    @(negedge clock); out_load = 1'b1; out_data = hi;
    @(negedge clock); out_load = 1'b1; out_data = lo;
    @(negedge clock); out_load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; out_load = 1'b0; out_data = '0; m_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (status !== 4'b0001) begin errors++; $display("FAIL reset_status: got %b want 0001", status); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", m_data); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic;
    logic [7:0] exp;
    @(negedge clock); out_load = 1'b1; out_data = 4'hA;
    @(negedge clock); out_load = 1'b1; out_data = 4'h5; q.push_back(8'hA5);
    checks++; if (status !== 4'b0011) begin errors++; $display("FAIL basic_pending: got %b want 0011", status); end
    @(negedge clock); out_load = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL basic_byte: got v=%b d=%h want v=1 d=a5", m_valid, m_data); end
    checks++; if (status !== 4'b0000) begin errors++; $display("FAIL basic_status: got %b want 0000", status); end
    exp = q.pop_front();
    checks++; if (m_data !== exp) begin errors++; $display("FAIL basic_sb: got %h want %h", m_data, exp); end
    m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    checks++; if (status !== 4'b0001 || m_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got s=%b v=%b want s=0001 v=0", status, m_valid); end
  endtask

  task automatic test_back_to_back;
    int n; logic [7:0] exp;
    @(negedge clock); out_load = 1'b1; out_data = 4'h1;
    @(negedge clock); out_data = 4'h2; q.push_back(8'h12);
    @(negedge clock); out_data = 4'h3;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h12) begin errors++; $display("FAIL b2b_first: got v=%b d=%h want v=1 d=12", m_valid, m_data); end
    @(negedge clock); out_data = 4'h4; q.push_back(8'h34);
    @(negedge clock); out_load = 1'b0;
    checks++; if (status !== 4'b0000) begin errors++; $display("FAIL b2b_status: got %b want 0000", status); end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      exp = q.pop_front();
      checks++; if (m_valid !== 1'b1 || m_data !== exp) begin errors++; $display("FAIL b2b_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp); end
      m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    end
  endtask

  task automatic test_fill;
    int n; logic [7:0] exp;
    for (int i = 1; i <= 4; i++) begin
      send_pair(4'(i), 4'(i + 8));
      q.push_back({4'(i), 4'(i + 8)});
    end
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL fill_full: got %b want 0100", status); end
    send_pair(4'h3, 4'hC);
    checks++; if (status !== 4'b1100) begin errors++; $display("FAIL fill_overflow: got %b want 1100", status); end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      exp = q.pop_front();
      checks++; if (m_valid !== 1'b1 || m_data !== exp) begin errors++; $display("FAIL fill_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp); end
      m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    end
    checks++; if (status !== 4'b1001) begin errors++; $display("FAIL fill_empty_err: got %b want 1001", status); end
    @(negedge clock); clr_err = 1'b1;
    @(negedge clock); clr_err = 1'b0;
    checks++; if (status !== 4'b0001) begin errors++; $display("FAIL fill_clr: got %b want 0001", status); end
  endtask

  task automatic test_wrap;
    int n; logic [7:0] exp;
    send_pair(4'hF, 4'h0);
    m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_pair(4'(i + 4), 4'(15 - i));
      q.push_back({4'(i + 4), 4'(15 - i)});
    end
    @(negedge clock); out_load = 1'b1; out_data = 4'hD;
    @(negedge clock); out_load = 1'b1; out_data = 4'hE; m_ready = 1'b1;
    exp = q.pop_front();
    checks++; if (m_data !== exp) begin errors++; $display("FAIL wrap_pop_head: got %h want %h", m_data, exp); end
    q.push_back(8'hDE);
    @(negedge clock); out_load = 1'b0; m_ready = 1'b0;
    checks++; if (status !== 4'b0100) begin errors++; $display("FAIL wrap_full_noerr: got %b want 0100", status); end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      exp = q.pop_front();
      checks++; if (m_valid !== 1'b1 || m_data !== exp) begin errors++; $display("FAIL wrap_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp); end
      m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    end
  endtask

  task automatic test_timeout;
    logic [7:0] exp;
    @(negedge clock); out_load = 1'b1; out_data = 4'h7;
    @(negedge clock); out_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (status[1] !== 1'b1 || status[3] !== 1'b0) begin errors++; $display("FAIL timeout_pend[%0d]: got %b want pend=1 err=0", i, status); end
      @(negedge clock);
    end
    checks++; if (status !== 4'b1001) begin errors++; $display("FAIL timeout_err: got %b want 1001", status); end
    clr_err = 1'b1; @(negedge clock); clr_err = 1'b0;
    send_pair(4'h1, 4'h2); q.push_back(8'h12);
    exp = q.pop_front();
    checks++; if (m_valid !== 1'b1 || m_data !== exp) begin errors++; $display("FAIL timeout_repair: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp); end
    m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
  endtask

  task automatic test_edges;
    int n; logic [7:0] exp;
    @(negedge clock); out_load = 1'b1; out_data = 4'h8;
    @(negedge clock); out_load = 1'b0;
    repeat (3) @(negedge clock);
    out_load = 1'b1; out_data = 4'h9; q.push_back(8'h89);
    @(negedge clock); out_load = 1'b0;
    checks++; if (status !== 4'b0000 || m_data !== 8'h89) begin errors++; $display("FAIL edge_load_on_timeout: got s=%b d=%h want s=0000 d=89", status, m_data); end
    for (int i = 0; i < 3; i++) begin
      send_pair(4'h2, 4'(i)); q.push_back({4'h2, 4'(i)});
    end
    @(negedge clock); out_load = 1'b1; out_data = 4'h6;
    @(negedge clock); out_data = 4'h6; clr_err = 1'b1;
    @(negedge clock); out_load = 1'b0; clr_err = 1'b0;
    checks++; if (status !== 4'b1100) begin errors++; $display("FAIL edge_clr_vs_overflow: got %b want 1100", status); end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      exp = q.pop_front();
      checks++; if (m_valid !== 1'b1 || m_data !== exp) begin errors++; $display("FAIL edge_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp); end
      m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    end
    clr_err = 1'b1; @(negedge clock); clr_err = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp;
    send_pair(4'hB, 4'h1);
    send_pair(4'hB, 4'h2);
    @(negedge clock); out_load = 1'b1; out_data = 4'hE;
    @(negedge clock); out_load = 1'b0;
    checks++; if (status !== 4'b0010) begin errors++; $display("FAIL rstmid_before: got %b want 0010", status); end
    reset = 1'b0; q.delete();
    #1;
    checks++; if (status !== 4'b0001 || m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL rstmid_cleared: got s=%b v=%b d=%h want s=0001 v=0 d=00", status, m_valid, m_data); end
    @(negedge clock); reset = 1'b1;
    send_pair(4'hC, 4'hD); q.push_back(8'hCD);
    exp = q.pop_front();
    checks++; if (m_valid !== 1'b1 || m_data !== exp || status !== 4'b0000) begin errors++; $display("FAIL rstmid_new: got v=%b d=%h s=%b want v=1 d=%h s=0000", m_valid, m_data, status, exp); end
    m_ready = 1'b1; @(negedge clock); m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single: got v=%b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_fill();
    test_wrap();
    test_timeout();
    test_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_port_rx.md
# nibble_port_rx

Responder for the processor's 4-bit output port: captures every nibble the core writes to its output register, pairs consecutive nibbles (high first, then low) into bytes, and buffers them in a small FIFO drained by a downstream consumer over a valid/ready handshake. A registered 4-bit status nibble is returned to the core's pushbutton input, so firmware can poll full/pending/error before writing. The block sits beside the core, on the same clock as the output register.

## Interface
- DEPTH, 4: FIFO depth in bytes; power of two, at least 2.
- TIMEOUT, 255: cycles allowed between the high and low nibble before the half byte is discarded; 1..255.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- out_load  in  1  core output-register load strobe, one cycle per write.
- out_data  in  4  nibble being loaded into the output register on that same edge.
- m_data  out  8  byte at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid and m_ready are both 1 at a rising edge.
- clr_err  in  1  one-cycle pulse that clears the sticky error bit.
- status  out  4  to core pushbutton input: [3] err (sticky), [2] full, [1] pending (high nibble held), [0] empty.

## Operation
- Pairing FSM has two states.
  - EXP_HI: on out_load, store out_data as the high nibble, clear the timer, and go to EXP_LO.
  - EXP_LO: on out_load, form byte {hi, out_data}, attempt a push, and go to EXP_HI.
  - EXP_LO without out_load: increment the timer. When the timer reaches TIMEOUT, discard the high nibble, set err, and go to EXP_HI.
- Timeout and out_load in the same cycle: the load wins, the byte is formed, and err is not set.
- Push acceptance:
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, err is set, and FIFO contents are unchanged.
- Pop: occurs when m_valid && m_ready; the head advances. Push and pop in the same cycle leave the count unchanged.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits, range 0..DEPTH.
- m_data: equals the head entry whenever m_valid is 1. Its value is don't-care while empty, but it must not change while m_valid=1 and m_ready=0.
- err:
  - Set by an overflow drop or a timeout.
  - Cleared by clr_err.
  - If a set condition and clr_err occur in the same cycle, the set wins.
- status[2:0] derive directly from the FIFO count and FSM state registers. No extra latency beyond those registers.

## Timing
- Reset values: FSM = EXP_HI, timer = 0, pointers and count = 0, err = 0. This gives m_valid = 0, m_data = 8'h00, status = 4'b0001.
- Reset asserted mid-pair or mid-drain: the pending nibble and all buffered bytes are lost, with no partial output.
- Byte latency: m_valid rises in the cycle after the edge that samples the low-nibble out_load.
- status latency:
  - pending is 1 from the cycle after the high-nibble load.
  - full and empty update the cycle after the push/pop edge.
- Firmware writes at most one nibble per instruction, so back-to-back out_load strobes are legal and must pair correctly. A stream hi, lo, hi, lo... on consecutive cycles yields one push every second cycle.
- Timer: err rises exactly TIMEOUT+1 cycles after the high-nibble edge when no further out_load arrives.

## Structure
- Shared package nibble_port_pkg holds:
  - FSM state encodings EXP_HI = 0, EXP_LO = 1.
  - Status bit indices STAT_ERR = 3, STAT_FULL = 2, STAT_PEND = 1, STAT_EMPTY = 0.
  - Default DEPTH and TIMEOUT.
- One sub-module: byte_fifo (parameter DEPTH), a synchronous FIFO with push/pop/full/empty/count. The pairing FSM, timer, and err logic stay in the top.

## Test plan
- Reset then idle: status = 4'b0001 and m_valid = 0. Loads 4'hA then 4'h5 on consecutive cycles with m_ready = 0 → m_data = 8'hA5 and m_valid = 1 one cycle later; status = 4'b0000.
- Fill with DEPTH = 4 and m_ready = 0: after four pairs status = 4'b0100. A fifth pair (8'h3C) → err set, status = 4'b1100, and the FIFO still holds the first four bytes in order.
- Full FIFO with the fifth pair's low nibble on the same cycle as a pop: the byte is accepted, count stays 4, err stays 0, and order is preserved across pointer wrap.
- Timeout with TIMEOUT = 3: load 4'h7 only → pending = 1 for 4 cycles, then err = 1 and pending = 0. Loads 4'h1, 4'h2 then give 8'h12, not 8'h71.
- A low-nibble load on the exact timeout cycle → byte formed and err = 0. A clr_err pulse coinciding with an overflow → err stays 1.
- Assert reset with the FIFO holding 2 bytes and pending = 1 → all outputs at reset values. After release, a new pair → a single correct byte.
